skctl_skstat_unit: RTL and testbench

- Parametrised successor to the single SKCTLS write register in the POKEY serial/keyboard path.
- Holds SKCTLS and decodes its fields.
- Generates init-entry/exit pulses, maintains sticky SKSTAT error flags (cleared by SKRES write) and synchronises raw serial input.
- Sits between the register-decode block and the serial/keyboard cores; supplies mode controls and the SKSTAT read value.

---
 rtl/skctl_skstat_unit.sv | 122 ++++++++++++
 tb/tb_skctl_skstat_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skctl_skstat_unit.sv
// POKEY SKCTLS control register and SKSTAT status unit.
// Decodes mode fields, pulses on init changes, keeps sticky errors, syncs serin.
module skctl_skstat_unit #(
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enn,
    input  logic       skctl_wren,
    input  logic       skres_wren,
    input  logic [7:0] D,
    input  logic       set_frame_err,
    input  logic       set_ser_ovr,
    input  logic       set_kbd_ovr,
    input  logic       serin_async,
    input  logic       shift_n,
    input  logic       key_held,
    input  logic       serin_busy,
    output logic [7:0] SKCTLS,
    output logic [7:0] SKSTAT,
    output logic       init,
    output logic       init_enter,
    output logic       init_exit,
    output logic       force_break,
    output logic [2:0] serial_mode,
    output logic       two_tone,
    output logic       kbd_scan_en,
    output logic       debounce_en
);

    // init level implied by the reset value, so no pulse follows reset
    localparam logic INIT_RST = ~(RESET_VAL[0] | RESET_VAL[1]);

    logic [7:0]             skctls_nxt;
    logic                   init_nxt;
    logic                   init_prev;
    logic                   frame_err;
    logic                   ser_ovr;
    logic                   kbd_ovr;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   serin_sync;

    // value SKCTLS takes at the coming enabled edge
    always_comb begin
        skctls_nxt = SKCTLS;
        if (skctl_wren) begin
            skctls_nxt = D;
        end
        init_nxt = ~(skctls_nxt[0] | skctls_nxt[1]);
    end

    // control register and init edge pulses, advanced once per machine cycle
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            SKCTLS     <= RESET_VAL;
            init_prev  <= INIT_RST;
            init_enter <= 1'b0;
            init_exit  <= 1'b0;
        end else if (enn) begin
            SKCTLS     <= skctls_nxt;
            init_prev  <= init_nxt;
            init_enter <= init_nxt & ~init_prev;
            init_exit  <= ~init_nxt & init_prev;
        end
    end

    // sticky error flags: init forces clear, set beats an SKRES write
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            ser_ovr   <= 1'b0;
            kbd_ovr   <= 1'b0;
        end else if (enn) begin
            if (init) begin
                frame_err <= 1'b0;
                ser_ovr   <= 1'b0;
                kbd_ovr   <= 1'b0;
            end else begin
                if (set_frame_err) begin
                    frame_err <= 1'b1;
                end else if (skres_wren) begin
                    frame_err <= 1'b0;
                end
                if (set_ser_ovr) begin
                    ser_ovr <= 1'b1;
                end else if (skres_wren) begin
                    ser_ovr <= 1'b0;
                end
                if (set_kbd_ovr) begin
                    kbd_ovr <= 1'b1;
                end else if (skres_wren) begin
                    kbd_ovr <= 1'b0;
                end
            end
        end
    end

    // serial input synchroniser, free running and idling at mark
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], serin_async};
        end
    end

    assign serin_sync = sync_q[SYNC_STAGES-1];

    // field decode and active-low status word
    always_comb begin
        init        = ~(SKCTLS[0] | SKCTLS[1]);
        force_break = SKCTLS[7];
        serial_mode = SKCTLS[6:4];
        two_tone    = SKCTLS[3];
        kbd_scan_en = SKCTLS[1];
        debounce_en = SKCTLS[0];
        SKSTAT      = {~frame_err, ~kbd_ovr, ~ser_ovr, serin_sync,
                       shift_n, ~key_held, ~serin_busy, 1'b1};
    end

endmodule

// File: tb/tb_skctl_skstat_unit.sv
// Self-checking bench for skctl_skstat_unit.
// Behavioural model compared every cycle plus directed literal checks.
module tb_skctl_skstat_unit;

    localparam int SYNC = 3;

    logic       clk = 1'b1;
    logic       reset;
    logic       enn = 1'b1;
    logic       skctl_wren = 1'b0;
    logic       skres_wren = 1'b0;
    logic [7:0] D = 8'h00;
    logic       set_frame_err = 1'b0;
    logic       set_ser_ovr = 1'b0;
    logic       set_kbd_ovr = 1'b0;
    logic       serin_async = 1'b1;
    logic       shift_n = 1'b1;
    logic       key_held = 1'b0;
    logic       serin_busy = 1'b0;
    logic [7:0] SKCTLS;
    logic [7:0] SKSTAT;
    logic       init;
    logic       init_enter;
    logic       init_exit;
    logic       force_break;
    logic [2:0] serial_mode;
    logic       two_tone;
    logic       kbd_scan_en;
    logic       debounce_en;

    int errors = 0;
    int checks = 0;
    bit run = 1'b0;

    skctl_skstat_unit #(
        .RESET_VAL  (8'h00),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enn          (enn),
        .skctl_wren   (skctl_wren),
        .skres_wren   (skres_wren),
        .D            (D),
        .set_frame_err(set_frame_err),
        .set_ser_ovr  (set_ser_ovr),
        .set_kbd_ovr  (set_kbd_ovr),
        .serin_async  (serin_async),
        .shift_n      (shift_n),
        .key_held     (key_held),
        .serin_busy   (serin_busy),
        .SKCTLS       (SKCTLS),
        .SKSTAT       (SKSTAT),
        .init         (init),
        .init_enter   (init_enter),
        .init_exit    (init_exit),
        .force_break  (force_break),
        .serial_mode  (serial_mode),
        .two_tone     (two_tone),
        .kbd_scan_en  (kbd_scan_en),
        .debounce_en  (debounce_en)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    logic [7:0] m_sk;
    logic       m_frame, m_ser, m_kbd;
    logic       m_enter, m_exit;
    logic       m_pin [SYNC];
    logic [7:0] m_wr;
    logic [7:0] m_stat;

    function automatic logic is_init(input logic [7:0] v);
        return (v & 8'h03) == 8'h00;
    endfunction

    function automatic logic sticky(input logic cur, input logic in_init,
                                    input logic set, input logic clr);
        if (in_init) return 1'b0;
        if (set) return 1'b1;
        if (clr) return 1'b0;
        return cur;
    endfunction

    assign m_wr = skctl_wren ? D : m_sk;
    assign m_stat = {~m_frame, ~m_kbd, ~m_ser, m_pin[SYNC-1],
                     shift_n, ~key_held, ~serin_busy, 1'b1};

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            m_sk    <= 8'h00;
            m_frame <= 1'b0;
            m_ser   <= 1'b0;
            m_kbd   <= 1'b0;
            m_enter <= 1'b0;
            m_exit  <= 1'b0;
            for (int i = 0; i < SYNC; i++) m_pin[i] <= 1'b1;
        end else begin
            m_pin[0] <= serin_async;
            for (int i = 1; i < SYNC; i++) m_pin[i] <= m_pin[i-1];
            if (enn) begin
                m_sk    <= m_wr;
                m_enter <= is_init(m_wr) && !is_init(m_sk);
                m_exit  <= !is_init(m_wr) && is_init(m_sk);
                m_frame <= sticky(m_frame, is_init(m_sk), set_frame_err, skres_wren);
                m_ser   <= sticky(m_ser, is_init(m_sk), set_ser_ovr, skres_wren);
                m_kbd   <= sticky(m_kbd, is_init(m_sk), set_kbd_ovr, skres_wren);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (run) begin
            chk("m_skctls", SKCTLS, m_sk);
            chk("m_skstat", SKSTAT, m_stat);
            chk("m_init", {7'd0, init}, {7'd0, is_init(m_sk)});
            chk("m_enter", {7'd0, init_enter}, {7'd0, m_enter});
            chk("m_exit", {7'd0, init_exit}, {7'd0, m_exit});
            chk("m_fields",
                {force_break, serial_mode, two_tone, 1'b0, kbd_scan_en, debounce_en},
                {m_sk[7:3], 1'b0, m_sk[1:0]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] v);
        skctl_wren = 1'b1;
        D = v;
        tick();
        skctl_wren = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        tick();
        tick();
        run = 1'b1;
        chk("rst_skctls", SKCTLS, 8'h00);
        chk("rst_skstat", SKSTAT, 8'hFF);
        chk("rst_init", {7'd0, init}, 8'h01);
        chk("rst_pulses", {6'd0, init_enter, init_exit}, 8'h00);
        reset = 1'b0;
        tick();
        chk("no_pulse_after_rst", {6'd0, init_enter, init_exit}, 8'h00);

        // leave init
        wr(8'h03);
        chk("wr03_skctls", SKCTLS, 8'h03);
        chk("wr03_init", {7'd0, init}, 8'h00);
        chk("wr03_pulses", {6'd0, init_enter, init_exit}, 8'h01);
        tick();
        chk("exit_one_cycle", {7'd0, init_exit}, 8'h00);

        // framing error sticky, then SKRES clears
        set_frame_err = 1'b1;
        tick();
        set_frame_err = 1'b0;
        chk("frame_set", SKSTAT, 8'h7F);
        repeat (10) tick();
        chk("frame_held", SKSTAT, 8'h7F);
        skres_wren = 1'b1;
        tick();
        skres_wren = 1'b0;
        chk("frame_clr", SKSTAT, 8'hFF);

        // set wins over simultaneous SKRES
        skres_wren = 1'b1;
        set_ser_ovr = 1'b1;
        tick();
        set_ser_ovr = 1'b0;
        chk("set_wins", SKSTAT, 8'hDF);
        tick();
        skres_wren = 1'b0;
        chk("lone_skres", SKSTAT, 8'hFF);

        // flags set, then return to init
        set_kbd_ovr = 1'b1;
        set_frame_err = 1'b1;
        tick();
        set_kbd_ovr = 1'b0;
        set_frame_err = 1'b0;
        chk("two_flags", SKSTAT, 8'h3F);
        wr(8'h00);
        chk("enter_pulse", {6'd0, init_enter, init_exit}, 8'h02);
        chk("flags_until_next", SKSTAT, 8'h3F);
        tick();
        chk("flags_cleared", SKSTAT, 8'hFF);
        set_kbd_ovr = 1'b1;
        tick();
        set_kbd_ovr = 1'b0;
        chk("kbd_ignored_init", SKSTAT, 8'hFF);

        // live inputs pass straight through
        shift_n = 1'b0;
        key_held = 1'b1;
        serin_busy = 1'b1;
        #1;
        chk("live_inputs", SKSTAT, 8'hF1);
        shift_n = 1'b1;
        key_held = 1'b0;
        serin_busy = 1'b0;

        // enn low: synchroniser still runs, writes ignored
        tick();
        enn = 1'b0;
        skctl_wren = 1'b1;
        D = 8'h03;
        serin_async = 1'b0;
        tick();
        chk("sync_e1", SKSTAT, 8'hFF);
        tick();
        chk("sync_e2", SKSTAT, 8'hFF);
        tick();
        chk("sync_e3", SKSTAT, 8'hEF);
        chk("wr_no_enn", SKCTLS, 8'h00);
        skctl_wren = 1'b0;
        serin_async = 1'b1;
        enn = 1'b1;
        repeat (4) tick();
        chk("sync_back", SKSTAT, 8'hFF);

        // pulse spans a whole enn period; set with enn=0 not captured
        wr(8'h03);
        enn = 1'b0;
        set_ser_ovr = 1'b1;
        tick();
        set_ser_ovr = 1'b0;
        chk("exit_holds_enn0", {7'd0, init_exit}, 8'h01);
        chk("set_no_enn", SKSTAT, 8'hFF);
        enn = 1'b1;
        tick();
        chk("exit_drops", {7'd0, init_exit}, 8'h00);

        // reset during enter pulse with flags set
        set_frame_err = 1'b1;
        set_ser_ovr = 1'b1;
        tick();
        set_frame_err = 1'b0;
        set_ser_ovr = 1'b0;
        chk("pre_rst_flags", SKSTAT, 8'h5F);
        wr(8'h00);
        enn = 1'b0;
        chk("pre_rst_enter", {7'd0, init_enter}, 8'h01);
        tick();
        #1;
        reset = 1'b1;
        #1;
        chk("async_skctls", SKCTLS, 8'h00);
        chk("async_skstat", SKSTAT, 8'hFF);
        chk("async_pulses", {6'd0, init_enter, init_exit}, 8'h00);
        tick();
        reset = 1'b0;
        enn = 1'b1;
        tick();

        wr(8'hF8);
        chk("f8_skctls", SKCTLS, 8'hF8);
        chk("f8_fields", {3'd0, force_break, serial_mode, two_tone}, 8'h1F);
        chk("f8_init", {6'd0, init, init_enter}, 8'h02);
        tick();
        tick();
        run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
